// File: rtl/sigmoid_pkg.sv
// Shared Q-format constants and piecewise-sigmoid breakpoints/offsets.
// Both sigmoid implementations import this package.
package sigmoid_pkg;

    localparam int IN_W      = 8;  // Q3.4 signed input
    localparam int FRAC_BITS = 4;
    localparam int OUT_W     = 8;  // Q0.8 unsigned output
    localparam int WIDE_W    = 9;  // headroom for the 256 - p symmetry step

    typedef logic [WIDE_W-1:0] wide_t;

    localparam wide_t BP0  = 9'd16;
    localparam wide_t BP1  = 9'd38;
    localparam wide_t BP2  = 9'd80;
    localparam wide_t OFF0 = 9'd128;
    localparam wide_t OFF1 = 9'd160;
    localparam wide_t OFF2 = 9'd216;
    localparam wide_t SAT  = 9'd255;
    localparam wide_t ONE  = 9'd256;

    // Magnitude of a Q3.4 code; -128 maps to 128, which still fits in 9 bits.
    function automatic wide_t abs_mag(input logic signed [IN_W-1:0] x);
        logic [IN_W-1:0] m;
        m = x[IN_W-1] ? $unsigned(-x) : $unsigned(x);
        return {1'b0, m};
    endfunction

endpackage

// File: rtl/sigmoid_lut.sv
// Exact sigmoid: round(256*sigma(x/16)) clamped to 255, from a constant ROM,
// followed by the output register.
module sigmoid_lut
    import sigmoid_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  x_in,
    output logic        [OUT_W-1:0] y_out
);

    logic [OUT_W-1:0] y_p1;

    // Indexed by the raw two's-complement code: 0..127 positive, 128..255 negative.
    function automatic logic [OUT_W-1:0] lut_sigmoid(input logic signed [IN_W-1:0] x);
        logic [IN_W-1:0] code;
        logic [OUT_W-1:0] y;
        code = $unsigned(x);
        y    = '0;
        case (code) inside
            8'd0: y = 8'd128;   8'd1: y = 8'd132;   8'd2: y = 8'd136;   8'd3: y = 8'd140;
            8'd4: y = 8'd144;   8'd5: y = 8'd148;   8'd6: y = 8'd152;   8'd7: y = 8'd156;
            8'd8: y = 8'd159;   8'd9: y = 8'd163;   8'd10: y = 8'd167;  8'd11: y = 8'd170;
            8'd12: y = 8'd174;  8'd13: y = 8'd177;  8'd14: y = 8'd181;  8'd15: y = 8'd184;
            8'd16: y = 8'd187;  8'd17: y = 8'd190;  8'd18: y = 8'd193;  8'd19: y = 8'd196;
            8'd20: y = 8'd199;  8'd21: y = 8'd202;  8'd22: y = 8'd204;  8'd23: y = 8'd207;
            8'd24: y = 8'd209;  8'd25: y = 8'd212;  8'd26: y = 8'd214;  8'd27: y = 8'd216;
            8'd28: y = 8'd218;  8'd29: y = 8'd220;  8'd30: y = 8'd222;  8'd31: y = 8'd224;
            8'd32: y = 8'd225;  8'd33: y = 8'd227;  8'd34: y = 8'd229;  8'd35: y = 8'd230;
            8'd36: y = 8'd232;  8'd37: y = 8'd233;  8'd38: y = 8'd234;  8'd39: y = 8'd235;
            8'd40: y = 8'd237;  8'd41: y = 8'd238;  8'd42: y = 8'd239;  8'd43: y = 8'd240;
            [8'd44:8'd45]: y = 8'd241;  8'd46: y = 8'd242;  8'd47: y = 8'd243;
            8'd48: y = 8'd244;  [8'd49:8'd50]: y = 8'd245;  [8'd51:8'd52]: y = 8'd246;
            8'd53: y = 8'd247;  [8'd54:8'd56]: y = 8'd248;  [8'd57:8'd58]: y = 8'd249;
            [8'd59:8'd61]: y = 8'd250;  [8'd62:8'd64]: y = 8'd251;  [8'd65:8'd68]: y = 8'd252;
            [8'd69:8'd73]: y = 8'd253;  [8'd74:8'd82]: y = 8'd254;  [8'd83:8'd127]: y = 8'd255;
            [8'd128:8'd156]: y = 8'd0;  [8'd157:8'd173]: y = 8'd1;  [8'd174:8'd182]: y = 8'd2;
            [8'd183:8'd187]: y = 8'd3;  [8'd188:8'd191]: y = 8'd4;  [8'd192:8'd194]: y = 8'd5;
            [8'd195:8'd197]: y = 8'd6;  [8'd198:8'd199]: y = 8'd7;  [8'd200:8'd202]: y = 8'd8;
            8'd203: y = 8'd9;   [8'd204:8'd205]: y = 8'd10;  [8'd206:8'd207]: y = 8'd11;
            8'd208: y = 8'd12;  8'd209: y = 8'd13;  8'd210: y = 8'd14;  [8'd211:8'd212]: y = 8'd15;
            8'd213: y = 8'd16;  8'd214: y = 8'd17;  8'd215: y = 8'd18;  8'd216: y = 8'd19;
            8'd217: y = 8'd21;  8'd218: y = 8'd22;  8'd219: y = 8'd23;  8'd220: y = 8'd24;
            8'd221: y = 8'd26;  8'd222: y = 8'd27;  8'd223: y = 8'd29;  8'd224: y = 8'd31;
            8'd225: y = 8'd32;  8'd226: y = 8'd34;  8'd227: y = 8'd36;  8'd228: y = 8'd38;
            8'd229: y = 8'd40;  8'd230: y = 8'd42;  8'd231: y = 8'd44;  8'd232: y = 8'd47;
            8'd233: y = 8'd49;  8'd234: y = 8'd52;  8'd235: y = 8'd54;  8'd236: y = 8'd57;
            8'd237: y = 8'd60;  8'd238: y = 8'd63;  8'd239: y = 8'd66;  8'd240: y = 8'd69;
            8'd241: y = 8'd72;  8'd242: y = 8'd75;  8'd243: y = 8'd79;  8'd244: y = 8'd82;
            8'd245: y = 8'd86;  8'd246: y = 8'd89;  8'd247: y = 8'd93;  8'd248: y = 8'd97;
            8'd249: y = 8'd100; 8'd250: y = 8'd104; 8'd251: y = 8'd108; 8'd252: y = 8'd112;
            8'd253: y = 8'd116; 8'd254: y = 8'd120; 8'd255: y = 8'd124;
            default: y = '0;
        endcase
        return y;
    endfunction

    // Stage p1: output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_p1 <= '0;
        end else begin
            y_p1 <= lut_sigmoid(x_in);
        end
    end

    assign y_out = y_p1;

endmodule

// File: rtl/sigmoid_piecewise.sv
// Piecewise-linear sigmoid: three shift-add segments on |x| plus saturation,
// mirrored to the negative side via 1 - sigma(|x|), then registered.
module sigmoid_piecewise
    import sigmoid_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  x_in,
    output logic        [OUT_W-1:0] y_out
);

    logic [OUT_W-1:0] y_p1;

    function automatic wide_t pos_segment(input wide_t a);
        wide_t p;
        if (a < BP0) begin
            p = OFF0 + (a << 2);
        end else if (a < BP1) begin
            p = OFF1 + (a << 1);
        end else if (a < BP2) begin
            p = OFF2 + (a >> 1);
        end else begin
            p = SAT;
        end
        return p;
    endfunction

    // Saturated tail on the negative side goes straight to 0 rather than 256 - 255.
    function automatic logic [OUT_W-1:0] pw_sigmoid(input logic signed [IN_W-1:0] x);
        wide_t a;
        wide_t p;
        wide_t y;
        a = abs_mag(x);
        p = pos_segment(a);
        if (!x[IN_W-1]) begin
            y = p;
        end else if (a >= BP2) begin
            y = '0;
        end else begin
            y = ONE - p;
        end
        return y[OUT_W-1:0];
    endfunction

    // Stage p1: output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_p1 <= '0;
        end else begin
            y_p1 <= pw_sigmoid(x_in);
        end
    end

    assign y_out = y_p1;

endmodule

// File: rtl/sigmoid_activation.sv
// Sigmoid activation stage: exact LUT and piecewise-linear results side by side,
// each with one cycle of latency.
module sigmoid_activation
    import sigmoid_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  x_in,
    output logic        [OUT_W-1:0] y_lut,
    output logic        [OUT_W-1:0] y_piecewise
);

    sigmoid_lut u_lut (
        .clk   (clk),
        .reset (reset),
        .x_in  (x_in),
        .y_out (y_lut)
    );

    sigmoid_piecewise u_piecewise (
        .clk   (clk),
        .reset (reset),
        .x_in  (x_in),
        .y_out (y_piecewise)
    );

endmodule

// File: tb/tb_sigmoid_activation.sv
// Bench for sigmoid_activation: scoreboard of expected LUT/piecewise results
// against a real-valued sigmoid and an integer segment model.
module tb_sigmoid_activation;

    logic              clk = 1'b0;
    logic              reset;
    logic signed [7:0] x_in;
    logic        [7:0] y_lut;
    logic        [7:0] y_piecewise;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] l;
        logic [7:0] p;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        int x;
        int lut;
        int pw;
    } dir_t;

    sigmoid_activation dut (
        .clk         (clk),
        .reset       (reset),
        .x_in        (x_in),
        .y_lut       (y_lut),
        .y_piecewise (y_piecewise)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int lut_ref(input int x);
        real s;
        int  v;
        s = 256.0 / (1.0 + $exp(-x / 16.0));
        v = int'($floor(s + 0.5));
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int pw_ref(input int x);
        int a;
        int p;
        a = (x < 0) ? -x : x;
        if (a >= 80)      p = 255;
        else if (a >= 38) p = 216 + a / 2;
        else if (a >= 16) p = 160 + 2 * a;
        else              p = 128 + 4 * a;
        if (x >= 0)  return p;
        if (a >= 80) return 0;
        return 256 - p;
    endfunction

    // Called at a falling edge: drive x, queue its expectation, compare one edge later.
    task automatic step(input int x);
        exp_t e;
        x_in = 8'(x);
        e.l  = 8'(lut_ref(x));
        e.p  = 8'(pw_ref(x));
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        check_val($sformatf("lut x=%0d", x), int'(y_lut), int'(e.l));
        check_val($sformatf("pw x=%0d", x), int'(y_piecewise), int'(e.p));
    endtask

    dir_t dir_tab[11] = '{
        '{16, 187, 192}, '{-16, 69, 64}, '{127, 255, 255}, '{-128, 0, 0},
        '{15, -1, 188}, '{37, -1, 234}, '{38, -1, 235}, '{79, -1, 255},
        '{80, -1, 255}, '{-40, -1, 20}, '{0, 128, 128}
    };

    initial begin
        logic [7:0] prev_l;
        logic [7:0] prev_p;
        int         diff;

        reset = 1'b1;
        x_in  = 8'sd64;
        #2 reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_val("rst_lut", int'(y_lut), 0);
            check_val("rst_pw", int'(y_piecewise), 0);
        end
        @(negedge clk);
        check_val("rst_lut_neg", int'(y_lut), 0);
        check_val("rst_pw_neg", int'(y_piecewise), 0);
        reset = 1'b1;

        step(0);
        check_val("first_lut", int'(y_lut), 128);
        check_val("first_pw", int'(y_piecewise), 128);

        foreach (dir_tab[i]) begin
            step(dir_tab[i].x);
            if (dir_tab[i].lut >= 0)
                check_val($sformatf("dir_lut x=%0d", dir_tab[i].x), int'(y_lut), dir_tab[i].lut);
            check_val($sformatf("dir_pw x=%0d", dir_tab[i].x), int'(y_piecewise), dir_tab[i].pw);
        end

        // Input changes after the edge must not leak into the registered outputs.
        x_in = 8'sd16;
        @(posedge clk);
        #2 x_in = -8'sd16;
        @(negedge clk);
        check_val("hold_lut", int'(y_lut), 187);
        check_val("hold_pw", int'(y_piecewise), 192);
        @(negedge clk);
        check_val("next_lut", int'(y_lut), 69);
        check_val("next_pw", int'(y_piecewise), 64);

        prev_l = '0;
        prev_p = '0;
        for (int i = -128; i <= 127; i++) begin
            step(i);
            if (i > -128) begin
                check_val($sformatf("lut_mono x=%0d", i), int'(y_lut >= prev_l), 1);
                check_val($sformatf("pw_mono x=%0d", i), int'(y_piecewise >= prev_p), 1);
            end
            diff = int'(y_lut) - int'(y_piecewise);
            if (diff < 0) diff = -diff;
            check_val($sformatf("gap x=%0d", i), int'(diff <= 6), 1);
            prev_l = y_lut;
            prev_p = y_piecewise;
        end

        for (int i = -20; i <= 20; i += 4) begin
            if (i == 0) begin
                @(posedge clk);
                #3 reset = 1'b0;
                #1;
                check_val("mid_rst_lut", int'(y_lut), 0);
                check_val("mid_rst_pw", int'(y_piecewise), 0);
                exp_q.delete();
                @(negedge clk);
                check_val("mid_rst_lut_hold", int'(y_lut), 0);
                check_val("mid_rst_pw_hold", int'(y_piecewise), 0);
                reset = 1'b1;
            end
            step(i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
